// File: rtl/data_mem_responder.sv
// data_mem_responder: multi-cycle valid/ready data memory applying RISC-V funct3 load/store modes
//
// Ports:
//   clk                    rising-edge clock
//   rst                    asynchronous active-low reset
//   req_valid/req_ready    request handshake (ready only while idle)
//   req_we                 1 = store, 0 = load
//   req_mode               funct3 access mode (B/H/W, BU/HU for loads)
//   req_addr               byte address, taken modulo DEPTH_BYTES
//   req_wdata              store data, low bytes used for B/H
//   resp_valid/resp_ready  response handshake; rdata/err held until taken
//   resp_rdata             extended load result, 0 for stores and errors
//   resp_err               illegal mode, or misaligned access when trapping
//
// Build option: define DMEM_MISALIGN_TRAP_EN to fault misaligned H/HU/W accesses
// instead of performing them byte-wise with address wrap.
module data_mem_responder #(
    parameter int DEPTH_BYTES = 4096,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_mode,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);
    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int CW = WAIT_CYCLES < 1 ? 1 : $clog2(WAIT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          we_q;
    logic [2:0]    mode_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   rdata_q, rdata_d;
    logic          err_q, err_d;
    logic [7:0]    mem_q [DEPTH_BYTES];

    logic          acc_we;
    logic [2:0]    acc_mode;
    logic [AW-1:0] acc_addr;
    logic [31:0]   acc_wdata;
    logic          illegal, misalign, go_resp, commit;
    logic [7:0]    b0, b1, b2, b3;
    logic [31:0]   ld;
    logic          unused_addr;

    assign unused_addr = ^req_addr[31:AW];

    // With WAIT_CYCLES=0 the array is accessed on the accept edge itself, so while
    // idle the operands come straight from the request port.
    assign acc_we    = state_q == S_IDLE ? req_we    : we_q;
    assign acc_mode  = state_q == S_IDLE ? req_mode  : mode_q;
    assign acc_addr  = state_q == S_IDLE ? req_addr[AW-1:0] : addr_q;
    assign acc_wdata = state_q == S_IDLE ? req_wdata : wdata_q;

    // 011/11x are undefined; BU/HU have no store counterpart.
    assign illegal = acc_mode[1:0] == 2'b11 || (acc_mode[2] && (acc_we || acc_mode[1]));
`ifdef DMEM_MISALIGN_TRAP_EN
    assign misalign = (acc_mode[0] && acc_addr[0]) || (acc_mode[1] && acc_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif
    assign err_d = illegal || misalign;

    // Each byte lane wraps independently inside the array.
    assign b0 = mem_q[acc_addr];
    assign b1 = mem_q[acc_addr + AW'(1)];
    assign b2 = mem_q[acc_addr + AW'(2)];
    assign b3 = mem_q[acc_addr + AW'(3)];
    assign ld = acc_mode[1] ? {b3, b2, b1, b0}
              : acc_mode[0] ? {{16{b1[7] & ~acc_mode[2]}}, b1, b0}
              : {{24{b0[7] & ~acc_mode[2]}}, b0};
    assign rdata_d = err_d || acc_we ? 32'b0 : ld;

    assign go_resp = state_q != S_RESP && state_d == S_RESP;
    // Gating on rst keeps a reset from committing a store through the comb path.
    assign commit  = go_resp && acc_we && !err_d && rst;

    assign req_ready  = state_q == S_IDLE;
    assign resp_valid = state_q == S_RESP;
    assign resp_rdata = rdata_q;
    assign resp_err   = err_q;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == S_IDLE && req_valid) begin
            state_d = WAIT_CYCLES == 0 ? S_RESP : S_WAIT;
            cnt_d   = CW'(WAIT_CYCLES);
        end else if (state_q == S_WAIT) begin
            cnt_d   = cnt_q - CW'(1);
            state_d = cnt_q == CW'(1) ? S_RESP : S_WAIT;
        end else if (state_q == S_RESP && resp_ready) begin
            state_d = S_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            mode_q  <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == S_IDLE) begin
                we_q    <= req_we;
                mode_q  <= req_mode;
                addr_q  <= req_addr[AW-1:0];
                wdata_q <= req_wdata;
            end
            if (go_resp) begin
                rdata_q <= rdata_d;
                err_q   <= err_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (commit) begin
            mem_q[acc_addr] <= acc_wdata[7:0];
            if (acc_mode[1:0] != 2'b00) mem_q[acc_addr + AW'(1)] <= acc_wdata[15:8];
            if (acc_mode[1]) begin
                mem_q[acc_addr + AW'(2)] <= acc_wdata[23:16];
                mem_q[acc_addr + AW'(3)] <= acc_wdata[31:24];
            end
        end
    end
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: randomized and directed self-checking bench against a byte-array reference model
module tb_data_mem_responder;
    localparam int DEPTH = 4096;
    localparam int WAITC = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_we = 1'b0;
    logic [2:0]  req_mode = 3'b0;
    logic [31:0] req_addr = 32'b0;
    logic [31:0] req_wdata = 32'b0;
    logic        resp_ready = 1'b0;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    int checks = 0;
    int errors = 0;
    logic [7:0] ref_mem [DEPTH];

    data_mem_responder #(.DEPTH_BYTES(DEPTH), .WAIT_CYCLES(WAITC)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_mode(req_mode), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_rdata(resp_rdata), .resp_err(resp_err)
    );

    always #5 clk = ~clk;

    task automatic ref_access(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                              input logic [31:0] wdata, output logic [31:0] rd, output logic er);
        int n;
        logic [31:0] val;
        n  = 1 << mode[1:0];
        er = !((mode == 3'd0 || mode == 3'd1 || mode == 3'd2) || (!we && (mode == 3'd4 || mode == 3'd5)));
`ifdef DMEM_MISALIGN_TRAP_EN
        if (!er && (addr % n) != 0) er = 1'b1;
`endif
        rd = 32'b0;
        if (er) return;
        if (we) begin
            for (int i = 0; i < n; i++) ref_mem[(addr + i) % DEPTH] = wdata[8*i +: 8];
        end else begin
            val = 32'b0;
            for (int i = 0; i < n; i++) val = val | (32'(ref_mem[(addr + i) % DEPTH]) << (8*i));
            if (mode < 3'd4 && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
            rd = val;
        end
    endtask

    // Starts and ends at a negedge with the DUT idle; next call issues back-to-back.
    task automatic xact(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                        input logic [31:0] wdata, input int hold,
                        output logic [31:0] rd, output logic er);
        int lat;
        req_we = we; req_mode = mode; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        checks++;
        if (req_ready !== 1'b1) begin errors++; $display("FAIL idle_ready got %b want 1", req_ready); end
        @(posedge clk);
        #1;
        req_we = $urandom_range(0, 1); req_mode = 3'($urandom); req_addr = $urandom; req_wdata = $urandom;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
            if (!resp_valid) begin
                checks++;
                if (req_ready !== 1'b0) begin errors++; $display("FAIL wait_ready got %b want 0", req_ready); end
            end
        end while (resp_valid !== 1'b1 && lat < 20);
        checks++;
        if (lat != WAITC + 1) begin errors++; $display("FAIL latency got %0d want %0d", lat, WAITC + 1); end
        rd = resp_rdata;
        er = resp_err;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            checks++;
            if (resp_valid !== 1'b1 || req_ready !== 1'b0 || resp_rdata !== rd || resp_err !== er) begin
                errors++;
                $display("FAIL hold valid=%b ready=%b rdata=%h err=%b want 1 0 %h %b",
                         resp_valid, req_ready, resp_rdata, resp_err, rd, er);
            end
        end
        req_valid = 1'b0;
        resp_ready = 1'b1;
        @(negedge clk);
        resp_ready = 1'b0;
        checks++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL after_handshake valid=%b ready=%b want 0 1", resp_valid, req_ready);
        end
    endtask

    task automatic run(input logic we, input logic [2:0] mode, input logic [31:0] addr,
                       input logic [31:0] wdata, input int hold, input string name,
                       input logic use_exp, input logic [31:0] exp_rd, input logic exp_er);
        logic [31:0] rd, mrd;
        logic er, mer;
        xact(we, mode, addr, wdata, hold, rd, er);
        ref_access(we, mode, addr, wdata, mrd, mer);
        checks++;
        if (rd !== mrd || er !== mer) begin
            errors++;
            $display("FAIL %s model we=%b mode=%0d addr=%h got %h/%b want %h/%b", name, we, mode, addr, rd, er, mrd, mer);
        end
        if (use_exp) begin
            checks++;
            if (rd !== exp_rd || er !== exp_er) begin
                errors++;
                $display("FAIL %s got %h/%b want %h/%b", name, rd, er, exp_rd, exp_er);
            end
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_init ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        run(1'b1, 3'd2, 32'h10, 32'h1234_5678, 0, "rst_sw", 1'b1, 32'h0, 1'b0);
        run(1'b0, 3'd2, 32'h10, 32'h0, 0, "rst_lw0", 1'b1, 32'h1234_5678, 1'b0);
        req_we = 1'b1; req_mode = 3'd2; req_addr = 32'h10; req_wdata = 32'hDEAD_BEEF; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0 || resp_rdata !== 32'b0 || resp_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid ready=%b valid=%b rdata=%h err=%b want 1 0 0 0", req_ready, resp_valid, resp_rdata, resp_err);
        end
        repeat (3) @(negedge clk);
        rst = 1'b1;
        run(1'b0, 3'd2, 32'h10, 32'h0, 0, "rst_abort", 1'b1, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_fill;
        for (int a = 0; a < 32; a++) run(1'b1, 3'd2, 32'(4*a), $urandom, 0, "fill_lo", 1'b0, 32'h0, 1'b0);
        for (int a = 0; a < 4; a++) run(1'b1, 3'd2, 32'hFF0 + 32'(4*a), $urandom, 0, "fill_hi", 1'b0, 32'h0, 1'b0);
    endtask

    task automatic test_load_ext;
        run(1'b1, 3'd2, 32'h20, 32'h8040_20F1, 0, "ext_sw", 1'b1, 32'h0, 1'b0);
        run(1'b0, 3'd0, 32'h20, 32'h0, 0, "ext_lb", 1'b1, 32'hFFFF_FFF1, 1'b0);
        run(1'b0, 3'd4, 32'h23, 32'h0, 0, "ext_lbu", 1'b1, 32'h0000_0080, 1'b0);
        run(1'b0, 3'd1, 32'h22, 32'h0, 0, "ext_lh", 1'b1, 32'hFFFF_8040, 1'b0);
        run(1'b0, 3'd5, 32'h22, 32'h0, 0, "ext_lhu", 1'b1, 32'h0000_8040, 1'b0);
    endtask

    task automatic test_byte_store;
        run(1'b1, 3'd2, 32'h20, 32'h1122_3344, 1, "sb_sw", 1'b1, 32'h0, 1'b0);
        run(1'b1, 3'd0, 32'h21, 32'hFFFF_FFAB, 0, "sb_sb", 1'b1, 32'h0, 1'b0);
        run(1'b0, 3'd2, 32'h20, 32'h0, 0, "sb_lw", 1'b1, 32'h1122_AB44, 1'b0);
        run(1'b1, 3'd1, 32'h26, 32'hFFFF_BEEF, 0, "sh_sh", 1'b1, 32'h0, 1'b0);
    endtask

    task automatic test_backpressure;
        run(1'b0, 3'd2, 32'h20, 32'h0, 5, "bp_lw", 1'b1, 32'h1122_AB44, 1'b0);
    endtask

    task automatic test_illegal;
        run(1'b0, 3'd3, 32'h20, 32'h0, 0, "ill_ld3", 1'b1, 32'h0, 1'b1);
        run(1'b0, 3'd7, 32'h20, 32'h0, 0, "ill_ld7", 1'b1, 32'h0, 1'b1);
        run(1'b1, 3'd4, 32'h20, 32'h5555_5555, 0, "ill_st4", 1'b1, 32'h0, 1'b1);
        run(1'b1, 3'd6, 32'h20, 32'h5555_5555, 0, "ill_st6", 1'b1, 32'h0, 1'b1);
        run(1'b0, 3'd2, 32'h20, 32'h0, 0, "ill_nowrite", 1'b1, 32'h1122_AB44, 1'b0);
    endtask

    task automatic test_misalign;
        run(1'b1, 3'd2, 32'h24, 32'h5566_7788, 0, "mis_sw", 1'b1, 32'h0, 1'b0);
`ifdef DMEM_MISALIGN_TRAP_EN
        run(1'b0, 3'd2, 32'h21, 32'h0, 0, "mis_lw", 1'b1, 32'h0, 1'b1);
        run(1'b0, 3'd1, 32'h23, 32'h0, 0, "mis_lh", 1'b1, 32'h0, 1'b1);
`else
        run(1'b0, 3'd2, 32'h21, 32'h0, 0, "mis_lw", 1'b1, 32'h8811_22AB, 1'b0);
        run(1'b0, 3'd1, 32'h23, 32'h0, 0, "mis_lh", 1'b1, 32'hFFFF_8811, 1'b0);
`endif
    endtask

    task automatic test_wrap;
        run(1'b1, 3'd2, 32'h0000_1FFE, 32'hCAFE_F00D, 0, "wrap_sw", 1'b0, 32'h0, 1'b0);
        run(1'b0, 3'd2, 32'h0000_0FFE, 32'h0, 0, "wrap_lw", 1'b0, 32'h0, 1'b0);
        run(1'b0, 3'd5, 32'hFFFF_FFFF, 32'h0, 0, "wrap_lhu", 1'b0, 32'h0, 1'b0);
        run(1'b1, 3'd2, 32'h0000_0FFC, 32'hA1B2_C3D4, 0, "wrap_sw4", 1'b0, 32'h0, 1'b0);
        run(1'b0, 3'd1, 32'h0000_0FFE, 32'h0, 0, "wrap_lh", 1'b1, 32'hFFFF_A1B2, 1'b0);
    endtask

    task automatic test_random;
        logic [31:0] addr;
        for (int i = 0; i < 200; i++) begin
            addr = ($urandom & 32'hFFFF_F000) | ((32'($urandom_range(0, 135)) + 32'hFF0) & 32'hFFF);
            run(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), addr, $urandom,
                $urandom_range(0, 3), "random", 1'b0, 32'h0, 1'b0);
        end
    endtask

    initial begin
        test_reset;
        test_fill;
        test_load_ext;
        test_byte_store;
        test_backpressure;
        test_illegal;
        test_misalign;
        test_wrap;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
